// File: rtl/cache_pkg.sv
// Shared I$ types: line, address and fta transaction-id layout used by the
// miss request generator and the response assembler.
package cache_pkg;

  typedef logic [31:0] address_t;

  localparam int unsigned ICACHE_BEATS = 2;

  typedef logic [511:0] icache_line_t;

  // tranid = {tid[1:0], beat[1:0]}
  typedef struct packed {
    logic [1:0] tid;
    logic [1:0] beat;
  } fta_tranid_t;

endpackage

// File: rtl/icache_resp_assembler.sv
// Assembles two 256-bit fta read beats into one 512-bit I$ line write and
// pulses ack to release the miss request generator.
module icache_resp_assembler
  import cache_pkg::*;
#(
  parameter logic [5:0] CORENO  = 6'd1,
  parameter logic [5:0] CID     = 6'd0,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               resp_v,
  output logic               resp_rdy,
  input  logic [5:0]         resp_core,
  input  logic [5:0]         resp_channel,
  input  logic [3:0]         resp_tranid,
  input  logic [255:0]       resp_dat,
  input  logic               resp_err,
  input  address_t           vtags [16],
  output logic               line_v,
  input  logic               line_rdy,
  output address_t           line_vadr,
  output icache_line_t       line_dat,
  output logic               line_err,
  output logic               ack,
  output logic [7:0]         drop_cnt
);

  typedef enum logic [1:0] {StIdle, StCollect, StWrite, StAck} state_e;

  state_e                  r_state, w_state_nxt;
  logic [1:0]              r_cur_tid, w_cur_tid_nxt;
  logic [ICACHE_BEATS-1:0] r_bv, w_bv_nxt;
  logic                    r_err, w_err_nxt;
  logic [7:0]              r_tmo, w_tmo_nxt;
  logic [7:0]              r_drop, w_drop_nxt;
  icache_line_t            r_dat, w_dat_nxt;
  address_t                r_vadr, w_vadr_nxt;

  fta_tranid_t w_tranid;
  logic        w_fire;
  logic        w_own_ch;
  logic        w_beat_ok;
  logic        w_idx;
  logic [7:0]  w_drop_inc;

  assign w_tranid   = fta_tranid_t'(resp_tranid);
  assign w_fire     = resp_v & resp_rdy;
  assign w_own_ch   = (resp_core == CORENO) && (resp_channel == CID);
  assign w_beat_ok  = ~w_tranid.beat[1];
  assign w_idx      = w_tranid.beat[0];
  assign w_drop_inc = (r_drop == 8'hFF) ? r_drop : r_drop + 8'd1;

  always_comb begin
    w_state_nxt   = r_state;
    w_cur_tid_nxt = r_cur_tid;
    w_bv_nxt      = r_bv;
    w_err_nxt     = r_err;
    w_tmo_nxt     = r_tmo;
    w_drop_nxt    = r_drop;
    w_dat_nxt     = r_dat;
    w_vadr_nxt    = r_vadr;

    unique case (r_state)
      StIdle: begin
        w_tmo_nxt = 8'd0;
        if (w_fire && w_own_ch) begin
          if (w_beat_ok) begin
            w_cur_tid_nxt   = w_tranid.tid;
            w_bv_nxt[w_idx] = 1'b1;
            w_err_nxt       = r_err | resp_err;
            if (w_idx) w_dat_nxt[511:256] = resp_dat;
            else       w_dat_nxt[255:0]   = resp_dat;
            w_state_nxt     = StCollect;
          end else begin
            w_drop_nxt = w_drop_inc;
          end
        end
      end

      StCollect: begin
        w_tmo_nxt = r_tmo + 8'd1;
        if (w_fire && w_own_ch) begin
          if (w_beat_ok && (w_tranid.tid == r_cur_tid) && !r_bv[w_idx]) begin
            w_bv_nxt[w_idx] = 1'b1;
            w_err_nxt       = r_err | resp_err;
            if (w_idx) w_dat_nxt[511:256] = resp_dat;
            else       w_dat_nxt[255:0]   = resp_dat;
          end else begin
            w_drop_nxt = w_drop_inc;
          end
        end
        // A completing beat on the timeout edge still wins.
        if (&w_bv_nxt) begin
          w_vadr_nxt  = vtags[{r_cur_tid, 2'b00}];
          w_state_nxt = StWrite;
        end else if (r_tmo == TIMEOUT - 8'd1) begin
          w_bv_nxt    = '0;
          w_state_nxt = StAck;
        end
      end

      StWrite: begin
        if (line_rdy) w_state_nxt = StAck;
      end

      StAck: begin
        w_bv_nxt    = '0;
        w_err_nxt   = 1'b0;
        w_state_nxt = StIdle;
      end

      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_cur_tid <= 2'd0;
      r_bv      <= '0;
      r_err     <= 1'b0;
      r_tmo     <= 8'd0;
      r_drop    <= 8'd0;
      r_dat     <= '0;
      r_vadr    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur_tid <= w_cur_tid_nxt;
      r_bv      <= w_bv_nxt;
      r_err     <= w_err_nxt;
      r_tmo     <= w_tmo_nxt;
      r_drop    <= w_drop_nxt;
      r_dat     <= w_dat_nxt;
      r_vadr    <= w_vadr_nxt;
    end
  end

  assign resp_rdy  = (r_state == StIdle) || (r_state == StCollect);
  assign ack       = (r_state == StAck);
  assign line_v    = (r_state == StWrite);
  assign line_vadr = r_vadr;
  assign line_dat  = r_dat;
  assign line_err  = r_err & line_v;
  assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_icache_resp_assembler.sv
// Directed bench for icache_resp_assembler: ordering, errors, foreign and
// dropped beats, timeout, write backpressure and mid-line reset.
module tb_icache_resp_assembler;

  logic         clk;
  logic         rst;
  logic         resp_v;
  logic         resp_rdy;
  logic [5:0]   resp_core;
  logic [5:0]   resp_channel;
  logic [3:0]   resp_tranid;
  logic [255:0] resp_dat;
  logic         resp_err;
  logic [31:0]  vtags [16];
  logic         line_v;
  logic         line_rdy;
  logic [31:0]  line_vadr;
  logic [511:0] line_dat;
  logic         line_err;
  logic         ack;
  logic [7:0]   drop_cnt;

  int n_checks;
  int n_errors;

  localparam logic [255:0] DatA = {8{32'hAAAA_0001}};
  localparam logic [255:0] DatB = {8{32'hBBBB_0002}};
  localparam logic [255:0] DatC = {8{32'hCCCC_0003}};
  localparam logic [255:0] DatD = {8{32'hDDDD_0004}};
  localparam logic [255:0] DatX = {8{32'h5A5A_A5A5}};

  icache_resp_assembler dut (
    .clk          (clk),
    .rst          (rst),
    .resp_v       (resp_v),
    .resp_rdy     (resp_rdy),
    .resp_core    (resp_core),
    .resp_channel (resp_channel),
    .resp_tranid  (resp_tranid),
    .resp_dat     (resp_dat),
    .resp_err     (resp_err),
    .vtags        (vtags),
    .line_v       (line_v),
    .line_rdy     (line_rdy),
    .line_vadr    (line_vadr),
    .line_dat     (line_dat),
    .line_err     (line_err),
    .ack          (ack),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All drive and sample points sit 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] core, input logic [3:0] tranid,
                      input logic [255:0] dat, input logic err);
    resp_v       = 1'b1;
    resp_core    = core;
    resp_channel = 6'd0;
    resp_tranid  = tranid;
    resp_dat     = dat;
    resp_err     = err;
    tick();
    resp_v   = 1'b0;
    resp_err = 1'b0;
  endtask

  initial begin
    int  cycles;
    bit  saw_line;
    bit  stable;
    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b0;
    resp_v       = 1'b0;
    resp_core    = 6'd1;
    resp_channel = 6'd0;
    resp_tranid  = 4'h0;
    resp_dat     = '0;
    resp_err     = 1'b0;
    line_rdy     = 1'b1;
    for (int i = 0; i < 16; i++) vtags[i] = 32'h1000 * (i / 4 + 1);
    #12;
    check_eq("rst_resp_rdy", resp_rdy, 1'b1);
    check_eq("rst_line_v", line_v, 1'b0);
    check_eq("rst_ack", ack, 1'b0);
    check_eq("rst_drop", drop_cnt, 8'd0);
    check_eq("rst_dat", line_dat, '0);
    rst = 1'b1;
    tick();

    // In-order line, tid 0
    send(6'd1, 4'h0, DatA, 1'b0);
    check_eq("t1_no_line_yet", line_v, 1'b0);
    send(6'd1, 4'h1, DatB, 1'b0);
    check_eq("t1_line_v", line_v, 1'b1);
    check_eq("t1_dat", line_dat, {DatB, DatA});
    check_eq("t1_vadr", line_vadr, 32'h1000);
    check_eq("t1_err", line_err, 1'b0);
    check_eq("t1_rdy_low", resp_rdy, 1'b0);
    tick();
    check_eq("t1_ack", ack, 1'b1);
    check_eq("t1_line_v_off", line_v, 1'b0);
    tick();
    check_eq("t1_ack_off", ack, 1'b0);
    check_eq("t1_rdy_back", resp_rdy, 1'b1);

    // Reversed order with error on beat0, tid 1
    send(6'd1, 4'h5, DatC, 1'b0);
    send(6'd1, 4'h4, DatD, 1'b1);
    check_eq("t2_line_v", line_v, 1'b1);
    check_eq("t2_dat", line_dat, {DatC, DatD});
    check_eq("t2_vadr", line_vadr, 32'h2000);
    check_eq("t2_err", line_err, 1'b1);
    tick();
    check_eq("t2_ack", ack, 1'b1);
    tick();

    // Foreign beat ignored, wrong-tid beat dropped
    send(6'd1, 4'h0, DatA, 1'b0);
    send(6'd2, 4'h1, DatX, 1'b0);
    check_eq("t3_foreign_no_line", line_v, 1'b0);
    check_eq("t3_foreign_drop", drop_cnt, 8'd0);
    send(6'd1, 4'h8, DatX, 1'b0);
    check_eq("t3_tid_drop", drop_cnt, 8'd1);
    check_eq("t3_no_line", line_v, 1'b0);
    send(6'd1, 4'h1, DatB, 1'b0);
    check_eq("t3_line_v", line_v, 1'b1);
    check_eq("t3_dat", line_dat, {DatB, DatA});
    check_eq("t3_err", line_err, 1'b0);
    tick();
    check_eq("t3_ack", ack, 1'b1);
    tick();

    // Timeout: only beat0 of tid 3 arrives
    send(6'd1, 4'hC, DatC, 1'b0);
    cycles   = 0;
    saw_line = 1'b0;
    while (!ack && cycles < 400) begin
      if (line_v) saw_line = 1'b1;
      tick();
      cycles++;
    end
    check_eq("t4_tmo_cycles", cycles, 255);
    check_eq("t4_no_line", saw_line, 1'b0);
    check_eq("t4_ack_line_v", line_v, 1'b0);
    tick();
    check_eq("t4_ack_off", ack, 1'b0);
    check_eq("t4_rdy", resp_rdy, 1'b1);

    // Write backpressure, tid 2
    line_rdy = 1'b0;
    send(6'd1, 4'h8, DatA, 1'b0);
    send(6'd1, 4'h9, DatD, 1'b0);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (line_v !== 1'b1 || line_dat !== {DatD, DatA} || resp_rdy !== 1'b0 ||
          ack !== 1'b0 || line_vadr !== 32'h3000)
        stable = 1'b0;
      tick();
    end
    check_eq("t5_stable", stable, 1'b1);
    line_rdy = 1'b1;
    tick();
    check_eq("t5_ack", ack, 1'b1);
    check_eq("t5_line_v_off", line_v, 1'b0);
    tick();

    // Reset mid-line, then a fresh line with dup / bad-beat drops
    send(6'd1, 4'h0, DatX, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t6_rst_rdy", resp_rdy, 1'b1);
    check_eq("t6_rst_drop", drop_cnt, 8'd0);
    check_eq("t6_rst_line_v", line_v, 1'b0);
    check_eq("t6_rst_ack", ack, 1'b0);
    check_eq("t6_rst_dat", line_dat, '0);
    #1;
    rst = 1'b1;
    tick();
    send(6'd1, 4'h2, DatX, 1'b0);
    check_eq("t6_idle_bad_beat", drop_cnt, 8'd1);
    send(6'd1, 4'h0, DatA, 1'b0);
    send(6'd1, 4'h0, DatX, 1'b0);
    check_eq("t6_dup_drop", drop_cnt, 8'd2);
    send(6'd1, 4'h3, DatX, 1'b0);
    check_eq("t6_bad_beat_drop", drop_cnt, 8'd3);
    send(6'd1, 4'h1, DatB, 1'b0);
    check_eq("t6_line_v", line_v, 1'b1);
    check_eq("t6_dat", line_dat, {DatB, DatA});
    check_eq("t6_err", line_err, 1'b0);
    tick();
    check_eq("t6_ack", ack, 1'b1);
    tick();
    check_eq("t6_ack_off", ack, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
